// File: rtl/uart_tx_queue.sv
// Byte FIFO plus launch sequencer that feeds the UART transmit/tx_byte/tx_free handshake.
// Optional lossy mode for never-stall sources: define UART_TXQ_DROP_EN.
module uart_tx_queue #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic                  uart_transmit,
  output logic [7:0]            uart_tx_byte,
  input  logic                  uart_tx_free,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic [7:0]            drop_count,
  output logic [1:0]            fsm_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t                  state;
  logic [7:0]              mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [DEPTH_LOG2:0]     count;
  logic                    push;
  logic                    pop;

  // Upstream handshake: a byte moves on in_valid & in_ready; in_ready depends
  // only on registered occupancy, so there is no path from in_valid to outputs.
  assign level     = count;
  assign empty     = (count == '0);
  assign full      = (count == FULL_LEVEL);
  assign fsm_state = state;

  // Flush wins over a push in the same cycle and also blocks a launch.
  assign push = in_valid && !full && !flush;
  assign pop  = (state == IDLE) && !empty && uart_tx_free && !flush;

`ifdef UART_TXQ_DROP_EN
  logic drop;

  assign in_ready = 1'b1;
  assign drop     = in_valid && full && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= 8'h00;
    end else if (drop && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end
`else
  assign in_ready   = !full;
  assign drop_count = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // LAUNCH is the cycle the UART samples transmit; HOLD covers tx_free falling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      uart_transmit <= 1'b0;
      uart_tx_byte  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            uart_tx_byte  <= mem[rd_ptr];
            uart_transmit <= 1'b1;
            state         <= LAUNCH;
          end
        end
        LAUNCH: begin
          uart_transmit <= 1'b0;
          state         <= HOLD;
        end
        HOLD: begin
          state <= IDLE;
        end
        default: begin
          uart_transmit <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte FIFO and launch sequencer placed directly upstream of the UART transmitter. It accepts bytes from the trace/packet source on a valid/ready interface and buffers them. It feeds them one at a time into the UART's `transmit`/`tx_byte`/`tx_free` handshake, so the source never has to track UART idle state. The UART can then run back-to-back frames without source-side gaps.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries (16). Legal range is 1..10.
- `clk  in  1`: system clock, the same clock as the UART.
- `rst  in  1`: synchronous, active-high reset.
- `in_data  in  8`: byte from upstream.
- `in_valid  in  1`: `in_data` is valid.
- `in_ready  out  1`: the queue accepts `in_data` this cycle. A push occurs on `in_valid & in_ready`.
- `flush  in  1`: synchronous discard of all queued bytes.
- `uart_transmit  out  1`: one-cycle launch pulse, connects to UART `transmit`.
- `uart_tx_byte  out  8`: byte to send, connects to UART `tx_byte`. Stable from launch until the next launch.
- `uart_tx_free  in  1`: from UART `tx_free`. High means the transmitter is idle.
- `level  out  DEPTH_LOG2+1`: number of queued bytes, 0..2^DEPTH_LOG2.
- `empty  out  1`: `level == 0`.
- `full  out  1`: `level == 2^DEPTH_LOG2`.
- `drop_count  out  8`: count of dropped bytes. Only meaningful with `UART_TXQ_DROP_EN` (see Configuration).

## Operation
- **Storage:** circular buffer of 2^DEPTH_LOG2 × 8 bits.
  - Write pointer, read pointer: DEPTH_LOG2 bits each, wrapping modulo depth.
  - Occupancy counter: DEPTH_LOG2+1 bits.
- **Push:** when `in_valid & in_ready`, write `in_data` at the write pointer, then increment the write pointer.
- **Pop:** occurs only on a launch (see below). The head byte is copied to `uart_tx_byte`, then the read pointer increments.
- **Simultaneous push and pop:** `level` is unchanged. Pushing into an empty queue while launching is impossible because launch requires `!empty` in the same cycle.
- **`in_ready`:** equals `!full` (combinational from `level`), except as modified by Configuration.
- **Launch FSM states:**
  - IDLE: if `!empty & uart_tx_free & !flush`, load `uart_tx_byte` with the head, pop, set `uart_transmit` to 1, go to LAUNCH. Otherwise stay.
  - LAUNCH: the UART samples `transmit` this cycle. Clear `uart_transmit` to 0, go to HOLD.
  - HOLD: one guard cycle while the UART's `tx_free` falls. Go to IDLE unconditionally.
- **`flush`:**
  - Sets both pointers and the occupancy counter to 0.
  - Has priority over a push in the same cycle; that byte is discarded and not counted as dropped.
  - Does not abort a byte already launched. The FSM completes LAUNCH and HOLD normally.
  - In IDLE, `flush` blocks launch that cycle.
- **Reset values:**
  - `uart_transmit` = 0, `uart_tx_byte` = 0x00, FSM = IDLE.
  - `level` = 0, `empty` = 1, `full` = 0, `in_ready` = 1, `drop_count` = 0.
  - Reset mid-frame abandons the queue. The UART frame in progress is the UART's own concern.

## Timing
- **Latency:** a byte pushed into an empty queue with the UART idle appears on `uart_transmit`/`uart_tx_byte` 2 edges after the push edge. Edge 1 updates `level`; edge 2 moves IDLE to LAUNCH.
- **`uart_transmit`:** high for exactly 1 cycle per byte, and only when `uart_tx_free` was high in the preceding IDLE cycle.
- **Launch spacing:** minimum 3 cycles between launches (IDLE → LAUNCH → HOLD). In practice spacing is bounded by the UART frame time.
- **Outputs:** `level`, `empty` and `full` reflect the state after the most recent edge.
- **Combinational paths:** none from `uart_tx_free` or `in_valid` to any output.

## Configuration
- **`UART_TXQ_DROP_EN` defined:**
  - `in_ready` is tied to 1. The trace source must never stall.
  - A push attempted while `full` (and not flushing) is discarded.
  - Each discard increments `drop_count`, which saturates at 0xFF.
  - `drop_count` clears only on `rst`.
- **`UART_TXQ_DROP_EN` undefined:**
  - Backpressure via `in_ready = !full`.
  - `drop_count` is constant 0x00.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `in_valid` = 1 → `level` = 0, `empty` = 1, `uart_transmit` = 0, `uart_tx_byte` = 0x00, no write occurs.
- **Single byte:** push 0xA5 with UART model idle → `uart_transmit` pulses once, 2 edges after the push, with `uart_tx_byte` = 0xA5. `level` returns to 0.
- **Burst and fill:** push 0x00..0x13 with the UART busy (`uart_tx_free` = 0) → `full` after 16 bytes. `in_ready` drops and bytes 0x10..0x13 are held by the source. On release, UART output order is 0x00..0x13 with no loss; the pointers wrap once.
- **Simultaneous push/pop at `level` = 5:** push in the launch cycle → `level` stays 5; the next launched byte is the old second entry.
- **Flush mid-stream:** flush while in LAUNCH with 7 bytes queued → the in-flight byte still pulses once, `level` = 0 next cycle, no further launches.
- **`UART_TXQ_DROP_EN`:** hold `uart_tx_free` = 0 and push 300 bytes into a 16-deep queue → `in_ready` stays 1, `level` = 16, `drop_count` = 0xFF (saturated).
